word_guess_engine: RTL and testbench

//  Parametrised letter-guessing game controller for the Caravel user area.

---
 rtl/word_guess_pkg.sv | 29 ++
 rtl/word_guess_engine_lfsr.sv | 21 ++
 rtl/word_guess_engine.sv | 152 +++++++++++++++
 tb/tb_word_guess_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_guess_pkg.sv
// Shared types and constants for the word-guessing game controller.
// Holds the FSM state encoding, default characters and the LFSR tap table.
package word_guess_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GUESS  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_WIN    = 3'd5,
    ST_LOSE   = 3'd6
  } state_t;

  localparam logic [7:0] CHAR_NUL   = 8'h00;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Maximal-length Fibonacci tap masks; bit k set means stage k+1 feeds back.
  function automatic logic [7:0] lfsr_taps(input int w);
    case (w)
      4:       lfsr_taps = 8'h0C;
      5:       lfsr_taps = 8'h14;
      6:       lfsr_taps = 8'h30;
      7:       lfsr_taps = 8'h60;
      default: lfsr_taps = 8'hB8;
    endcase
  endfunction

endpackage

// File: rtl/word_guess_engine_lfsr.sv
// Free-running Fibonacci LFSR, W bits wide, reset to 1 so it never locks at zero.
// Advances every cycle; no backpressure.
module lfsr_gen
  import word_guess_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] value
);

  localparam logic [7:0]   TAPS8 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS  = TAPS8[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= W'(1);
    else     value <= {value[W-2:0], ^(value & TAPS)};
  end

endmodule

// File: rtl/word_guess_engine.sv
// Letter-guessing game controller: one guess per next_i in GUESS, hit/miss pulse two cycles later.
// Optional WG_REPEAT_FILTER_EN adds a used-letter map that makes repeat guesses free.
module word_guess_engine
  import word_guess_pkg::*;
#(
  parameter  int CHAR_W    = 8,
  parameter  int WORD_LEN  = 5,
  parameter  int MAX_TRIES = 7,
  parameter  int NUM_WORDS = 8,
  parameter  int LFSR_W    = 6,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       next_i,
  input  logic [CHAR_W-1:0]          guess_i,
  output logic [IDX_W-1:0]           word_idx_o,
  input  logic [WORD_LEN*CHAR_W-1:0] word_i,
  output logic                       ready_o,
  output logic [WORD_LEN-1:0]        revealed_o,
  output logic [TRY_W-1:0]           tries_o,
  output logic                       hit_o,
  output logic                       miss_o,
  output logic                       repeat_o,
  output logic                       win_o,
  output logic                       lose_o,
  output logic [2:0]                 state_o
);

  state_t                      state, state_nxt;
  logic [LFSR_W-1:0]           lfsr;
  logic [WORD_LEN*CHAR_W-1:0]  word_reg;
  logic [CHAR_W-1:0]           guess_reg;
  logic [WORD_LEN-1:0]         match, match_reg;
  logic [WORD_LEN-1:0]         revealed;
  logic [TRY_W-1:0]            tries, tries_inc;
  logic                        rep_reg;
  logic                        all_rev;
  logic                        out_of_tries;

  lfsr_gen #(.W(LFSR_W)) u_lfsr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .value (lfsr)
  );

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_match
    assign match[i] = (word_reg[i*CHAR_W +: CHAR_W] == guess_reg);
  end

  assign tries_inc    = tries + TRY_W'(1);
  assign out_of_tries = (tries_inc == TRY_W'(MAX_TRIES));
  assign all_rev      = &(revealed | match_reg);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    hit_o     = 1'b0;
    miss_o    = 1'b0;
    repeat_o  = 1'b0;
    win_o     = 1'b0;
    lose_o    = 1'b0;
    case (state)
      ST_INIT:  if (next_i) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_GUESS;
      ST_GUESS: begin
        ready_o = 1'b1;
        if (next_i) state_nxt = ST_CHECK;
      end
      ST_CHECK: state_nxt = ST_UPDATE;
      ST_UPDATE: begin
        if (rep_reg) begin
          repeat_o  = 1'b1;
          state_nxt = ST_GUESS;
        end else if (|match_reg) begin
          hit_o     = 1'b1;
          state_nxt = all_rev ? ST_WIN : ST_GUESS;
        end else begin
          miss_o    = 1'b1;
          state_nxt = out_of_tries ? ST_LOSE : ST_GUESS;
        end
      end
      ST_WIN: begin
        win_o = 1'b1;
        if (next_i) state_nxt = ST_INIT;
      end
      ST_LOSE: begin
        lose_o = 1'b1;
        if (next_i) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      word_idx_o <= '0;
      word_reg   <= '0;
      guess_reg  <= '0;
      match_reg  <= '0;
      revealed   <= '0;
      tries      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          revealed <= '0;
          tries    <= '0;
          if (next_i) word_idx_o <= IDX_W'(lfsr % NUM_WORDS);
        end
        ST_LOAD:  word_reg <= word_i;
        ST_GUESS: if (next_i) guess_reg <= guess_i;
        ST_CHECK: match_reg <= match;
        ST_UPDATE: begin
          if (!rep_reg) begin
            if (|match_reg)                          revealed <= revealed | match_reg;
            else if (tries != TRY_W'(MAX_TRIES))     tries    <= tries_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WG_REPEAT_FILTER_EN
  logic [2**CHAR_W-1:0] used_map;

  // rep_reg is captured in CHECK so UPDATE sees only letters used by earlier guesses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      used_map <= '0;
      rep_reg  <= 1'b0;
    end else begin
      if (state == ST_INIT)        used_map            <= '0;
      else if (state == ST_UPDATE) used_map[guess_reg] <= 1'b1;
      if (state == ST_CHECK)       rep_reg             <= used_map[guess_reg];
    end
  end
`else
  assign rep_reg = 1'b0;
`endif

  assign revealed_o = revealed;
  assign tries_o    = tries;
  assign state_o    = state;

endmodule

// File: tb/tb_word_guess_engine.sv
// Self-checking bench for word_guess_engine with a "HELLO" word table and a guess scoreboard.
module tb_word_guess_engine;

`ifdef WG_REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic       rep;
    logic [4:0] rev;
    logic [2:0] tries;
    logic       win;
    logic       lose;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next_i = 1'b0;
  logic [7:0]  guess_i = 8'h00;
  logic [2:0]  word_idx;
  logic [39:0] word_i;
  logic        ready, hit, miss, rep, win, lose;
  logic [4:0]  revealed;
  logic [2:0]  tries;
  logic [2:0]  state;

  logic [39:0]  word_hello = 40'h4F4C4C4548;
  logic [4:0]   m_rev;
  logic [2:0]   m_tries;
  logic [255:0] m_used;
  exp_t         sb[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  assign word_i = word_hello;

  always #5 clk = ~clk;

  word_guess_engine #(
    .CHAR_W(8), .WORD_LEN(5), .MAX_TRIES(7), .NUM_WORDS(5), .LFSR_W(6)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .next_i     (next_i),
    .guess_i    (guess_i),
    .word_idx_o (word_idx),
    .word_i     (word_i),
    .ready_o    (ready),
    .revealed_o (revealed),
    .tries_o    (tries),
    .hit_o      (hit),
    .miss_o     (miss),
    .repeat_o   (rep),
    .win_o      (win),
    .lose_o     (lose),
    .state_o    (state)
  );

  task automatic start_game();
    next_i = 1'b1;
    @(negedge clk);
    next_i = 1'b0;
    @(negedge clk);
    m_rev = '0; m_tries = '0; m_used = '0;
    tests_run++;
    if (ready !== 1'b1 || state !== 3'd2) begin
      tests_failed++;
      $display("FAIL start_game: ready=%b state=%0d, want ready=1 state=2", ready, state);
    end
  endtask

  task automatic finish_game();
    next_i = 1'b1;
    @(negedge clk);
    next_i = 1'b0;
    tests_run++;
    if (state !== 3'd0 || win !== 1'b0 || lose !== 1'b0) begin
      tests_failed++;
      $display("FAIL finish_game: state=%0d win=%b lose=%b, want state=0 win=0 lose=0", state, win, lose);
    end
    @(negedge clk);
  endtask

  task automatic do_guess(input logic [7:0] c);
    exp_t       e, got_e;
    logic [4:0] m;
    int         lat;
    bit         got;
    for (int i = 0; i < 5; i++) m[i] = (word_hello[i*8 +: 8] == c);
    e = '0;
    e.rep = FILTER && m_used[c];
    if (!e.rep) begin
      m_used[c] = 1'b1;
      if (m != 5'b0) begin
        e.hit = 1'b1;
        m_rev = m_rev | m;
      end else begin
        e.miss = 1'b1;
        if (m_tries < 3'd7) m_tries = m_tries + 3'd1;
      end
    end
    e.rev   = m_rev;
    e.tries = m_tries;
    e.win   = e.hit && (&m_rev);
    e.lose  = e.miss && (m_tries == 3'd7);
    sb.push_back(e);

    guess_i = c;
    next_i  = 1'b1;
    @(negedge clk);
    next_i = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      if ((hit | miss | rep) === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    got_e = sb.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL guess_%c timeout: no hit/miss/repeat pulse within %0d cycles", c, lat);
      return;
    end
    if ({hit, miss, rep} !== {got_e.hit, got_e.miss, got_e.rep} || lat != 2) begin
      tests_failed++;
      $display("FAIL guess_%c pulse: hit/miss/rep=%b%b%b after %0d cycles, want %b%b%b after 2",
               c, hit, miss, rep, lat, got_e.hit, got_e.miss, got_e.rep);
    end
    @(negedge clk);
    tests_run++;
    if (revealed !== got_e.rev || tries !== got_e.tries || win !== got_e.win ||
        lose !== got_e.lose || ready !== !(got_e.win || got_e.lose)) begin
      tests_failed++;
      $display("FAIL guess_%c result: rev=%b tries=%0d win=%b lose=%b ready=%b, want rev=%b tries=%0d win=%b lose=%b ready=%b",
               c, revealed, tries, win, lose, ready, got_e.rev, got_e.tries, got_e.win, got_e.lose,
               !(got_e.win || got_e.lose));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state !== 3'd0 || ready !== 1'b0 || revealed !== 5'b0 || tries !== 3'd0 || word_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d ready=%b rev=%b tries=%0d idx=%0d, want all 0",
               state, ready, revealed, tries, word_idx);
    end
    tests_run++;
    if ({hit, miss, rep, win, lose} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: hit/miss/rep/win/lose=%b, want 00000", {hit, miss, rep, win, lose});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit();
    start_game();
    do_guess("L");
    tests_run++;
    if (revealed !== 5'b01100 || tries !== 3'd0) begin
      tests_failed++;
      $display("FAIL hit_L: rev=%b tries=%0d, want rev=01100 tries=0", revealed, tries);
    end
    do_guess("L");
    do_guess("H");
    do_guess("E");
    do_guess("O");
    finish_game();
  endtask

  task automatic test_win();
    start_game();
    do_guess("H");
    do_guess("E");
    do_guess("L");
    do_guess("O");
    @(negedge clk);
    tests_run++;
    if (revealed !== 5'b11111 || win !== 1'b1 || lose !== 1'b0 || state !== 3'd5) begin
      tests_failed++;
      $display("FAIL win_hold: rev=%b win=%b lose=%b state=%0d, want rev=11111 win=1 lose=0 state=5",
               revealed, win, lose, state);
    end
    finish_game();
    tests_run++;
    if (revealed !== 5'b0 || tries !== 3'd0) begin
      tests_failed++;
      $display("FAIL init_clear: rev=%b tries=%0d, want rev=00000 tries=0", revealed, tries);
    end
  endtask

  task automatic test_lose();
    logic [7:0] misses [7] = '{"A", "B", "C", "D", "F", "G", "I"};
    start_game();
    foreach (misses[i]) do_guess(misses[i]);
    repeat (3) @(negedge clk);
    tests_run++;
    if (tries !== 3'd7 || lose !== 1'b1 || win !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL lose_hold: tries=%0d lose=%b win=%b ready=%b, want tries=7 lose=1 win=0 ready=0",
               tries, lose, win, ready);
    end
    finish_game();
  endtask

  task automatic test_repeat();
    start_game();
    do_guess("Z");
    do_guess("Z");
    tests_run++;
    if (tries !== (FILTER ? 3'd1 : 3'd2)) begin
      tests_failed++;
      $display("FAIL repeat_Z: tries=%0d, want %0d", tries, FILTER ? 1 : 2);
    end
    do_guess("H");
    do_guess("E");
    do_guess("L");
    do_guess("O");
    finish_game();
  endtask

  task automatic test_reset_mid_update();
    start_game();
    guess_i = "Q";
    next_i  = 1'b1;
    @(negedge clk);
    next_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state !== 3'd4 || miss !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_update_reach: state=%0d miss=%b, want state=4 miss=1", state, miss);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state !== 3'd0 || revealed !== 5'b0 || tries !== 3'd0 || {hit, miss, rep, win, lose} !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_update_reset: state=%0d rev=%b tries=%0d pulses=%b, want all 0",
               state, revealed, tries, {hit, miss, rep, win, lose});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_idx();
    logic [4:0] seen = '0;
    for (int g = 0; g < 64; g++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      start_game();
      tests_run++;
      if (word_idx >= 3'd5) begin
        tests_failed++;
        $display("FAIL word_idx_range game %0d: idx=%0d, want <5", g, word_idx);
      end else begin
        seen[word_idx] = 1'b1;
      end
      do_guess("H");
      do_guess("E");
      do_guess("L");
      do_guess("O");
      finish_game();
    end
    tests_run++;
    if (seen !== 5'b11111) begin
      tests_failed++;
      $display("FAIL word_idx_coverage: seen=%b, want 11111", seen);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_win();
    test_lose();
    test_repeat();
    test_reset_mid_update();
    test_word_idx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
